// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite frame sequencer.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } anim_state_t;

  localparam int SPRITE_SIZE = 32;
  localparam int LUT_COORD_W = 5;

endpackage

// File: rtl/sprite_anim_fsm.sv
// Animation controller: play/pause FSM, display-frame tick counter and
// current frame index. Optional macro SPRITE_PINGPONG_EN selects a
// bouncing frame order instead of a wrapping one.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | stopped at frame 0 after reset/restart, waiting for play
// ST_PLAY  | counting frame_ticks and advancing frames
// ST_PAUSE | holding the current frame and tick count until play
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES      = 4,
  parameter int TICKS_PER_FRAME = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       play,
  input  logic       restart,
  output logic [2:0] frame_sel
);

  localparam logic [2:0] LAST_FRAME = 3'(NUM_FRAMES - 1);
  localparam logic [7:0] LAST_TICK  = 8'(TICKS_PER_FRAME - 1);

  anim_state_t state_q, state_d;
  logic [7:0]  tick_q, tick_d;
  logic [2:0]  frame_q, frame_d;
  logic [2:0]  frame_nxt;
`ifdef SPRITE_PINGPONG_EN
  logic        dir_q, dir_d, dir_nxt;   // 0 = forward, 1 = backward
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Counter, frame index and direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      frame_q <= '0;
`ifdef SPRITE_PINGPONG_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      tick_q  <= tick_d;
      frame_q <= frame_d;
`ifdef SPRITE_PINGPONG_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // Frame that follows the current one in the animation order.
  always_comb begin
    frame_nxt = '0;
`ifdef SPRITE_PINGPONG_EN
    dir_nxt = dir_q;
    if (NUM_FRAMES == 1) begin
      frame_nxt = '0;
    end else if (!dir_q) begin
      if (frame_q == LAST_FRAME) begin
        frame_nxt = frame_q - 3'd1;
        dir_nxt   = 1'b1;
      end else begin
        frame_nxt = frame_q + 3'd1;
      end
    end else begin
      if (frame_q == 3'd0) begin
        frame_nxt = 3'd1;
        dir_nxt   = 1'b0;
      end else begin
        frame_nxt = frame_q - 3'd1;
      end
    end
`else
    frame_nxt = (frame_q == LAST_FRAME) ? 3'd0 : frame_q + 3'd1;
`endif
  end

  // Next-state, tick counting and frame advance; restart overrides all.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    frame_d = frame_q;
`ifdef SPRITE_PINGPONG_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      ST_IDLE:  if (play)  state_d = ST_PLAY;
      ST_PLAY:  if (!play) state_d = ST_PAUSE;
      ST_PAUSE: if (play)  state_d = ST_PLAY;
      default:             state_d = ST_IDLE;
    endcase
    if (state_q == ST_PLAY && frame_tick) begin
      if (tick_q == LAST_TICK) begin
        tick_d  = '0;
        frame_d = frame_nxt;
`ifdef SPRITE_PINGPONG_EN
        dir_d   = dir_nxt;
`endif
      end else begin
        tick_d = tick_q + 8'd1;
      end
    end
    if (restart) begin
      state_d = ST_IDLE;
      tick_d  = '0;
      frame_d = '0;
`ifdef SPRITE_PINGPONG_EN
      dir_d   = 1'b0;
`endif
    end
  end

  assign frame_sel = frame_q;

endmodule

// File: rtl/sprite_frame_sequencer.sv
// Sprite frame sequencer top: animation controller plus a two-stage
// coordinate/colour pipeline (beam position -> LUT address -> colour).
// Optional macro SPRITE_PINGPONG_EN enables bouncing frame order.
module sprite_frame_sequencer
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES      = 4,
  parameter int TICKS_PER_FRAME = 6,
  parameter int SCALE_LOG2      = 2,
  parameter int SPRITE_X0       = 256,
  parameter int SPRITE_Y0       = 176
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             hpos,
  input  logic [9:0]             vpos,
  input  logic                   frame_tick,
  input  logic                   play,
  input  logic                   restart,
  input  logic [2:0]             pixel_in,
  output logic [LUT_COORD_W-1:0] lut_x,
  output logic [LUT_COORD_W-1:0] lut_y,
  output logic [2:0]             frame_sel,
  output logic [2:0]             color_idx,
  output logic                   sprite_on
);

  localparam int unsigned BOX_W = SPRITE_SIZE << SCALE_LOG2;
  localparam int unsigned X_LO  = SPRITE_X0;
  localparam int unsigned X_HI  = SPRITE_X0 + BOX_W;
  localparam int unsigned Y_LO  = SPRITE_Y0;
  localparam int unsigned Y_HI  = SPRITE_Y0 + BOX_W;

  logic                   in_box, in_box_q;
  logic [LUT_COORD_W-1:0] lut_x_d, lut_y_d;

  sprite_anim_fsm #(
    .NUM_FRAMES      (NUM_FRAMES),
    .TICKS_PER_FRAME (TICKS_PER_FRAME)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .play       (play),
    .restart    (restart),
    .frame_sel  (frame_sel)
  );

  // Box hit test and scaled LUT coordinates; zero address outside the box.
  always_comb begin
    in_box = (32'(hpos) >= X_LO) && (32'(hpos) < X_HI) &&
             (32'(vpos) >= Y_LO) && (32'(vpos) < Y_HI);
    lut_x_d = '0;
    lut_y_d = '0;
    if (in_box) begin
      lut_x_d = LUT_COORD_W'((hpos - 10'(SPRITE_X0)) >> SCALE_LOG2);
      lut_y_d = LUT_COORD_W'((vpos - 10'(SPRITE_Y0)) >> SCALE_LOG2);
    end
  end

  // Stage 1: register LUT address and box flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_x    <= '0;
      lut_y    <= '0;
      in_box_q <= 1'b0;
    end else begin
      lut_x    <= lut_x_d;
      lut_y    <= lut_y_d;
      in_box_q <= in_box;
    end
  end

  // Stage 2: register final colour; outside the box is background.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_idx <= '0;
      sprite_on <= 1'b0;
    end else begin
      color_idx <= in_box_q ? pixel_in : 3'd0;
      sprite_on <= in_box_q && (pixel_in != 3'd0);
    end
  end

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Self-checking bench for sprite_frame_sequencer (default parameters).
// Honours SPRITE_PINGPONG_EN in its reference model.
module tb_sprite_frame_sequencer;

  localparam int NF  = 4;
  localparam int TPF = 6;
  localparam int SCL = 2;
  localparam int X0  = 256;
  localparam int Y0  = 176;
  localparam int BOX = 32 << SCL;

  logic       clk = 1'b0;
  logic       rst, frame_tick, play, restart;
  logic [9:0] hpos, vpos;
  logic [2:0] pixel_in;
  logic [4:0] lut_x, lut_y;
  logic [2:0] frame_sel, color_idx;
  logic       sprite_on;

  int n_vec = 0;
  int n_err = 0;

  int m_cnt = 0;
  int m_k   = 0;
  bit m_act = 1'b0;

  always #5 clk = ~clk;

  sprite_frame_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .hpos       (hpos),
    .vpos       (vpos),
    .frame_tick (frame_tick),
    .play       (play),
    .restart    (restart),
    .pixel_in   (pixel_in),
    .lut_x      (lut_x),
    .lut_y      (lut_y),
    .frame_sel  (frame_sel),
    .color_idx  (color_idx),
    .sprite_on  (sprite_on)
  );

  // Frame LUT contents: an arbitrary pattern with zeros and all colours.
  function automatic logic [2:0] lut_fn(int f, int x, int y);
    return 3'((x + 3 * y + f) % 8);
  endfunction

  always_comb pixel_in = lut_fn(int'(frame_sel), int'(lut_x), int'(lut_y));

  // Frame shown after k completed holds.
  function automatic int fmap(int k);
    int per;
`ifdef SPRITE_PINGPONG_EN
    if (NF == 1) return 0;
    per = 2 * NF - 2;
    k = k % per;
    return (k < NF) ? k : per - k;
`else
    per = NF;
    return k % per;
`endif
  endfunction

  function automatic bit box_hit(int h, int v);
    return (h >= X0) && (h < X0 + BOX) && (v >= Y0) && (v < Y0 + BOX);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given controls; model advances and frame_sel is checked.
  task automatic cycle(input bit t, input bit p, input bit r, input bit x);
    frame_tick = t; play = p; restart = r; rst = x;
    @(posedge clk); #1;
    if (x || r) begin
      m_cnt = 0; m_k = 0; m_act = 1'b0;
    end else begin
      if (m_act && t) begin
        if (m_cnt == TPF - 1) begin
          m_cnt = 0; m_k++;
        end else begin
          m_cnt++;
        end
      end
      m_act = p;
    end
    chk("frame_sel", int'(frame_sel), fmap(m_k));
    frame_tick = 1'b0; restart = 1'b0; rst = 1'b0;
  endtask

  int dh[6] = '{383, 384, 256, 276, 255, 300};
  int dv[6] = '{176, 176, 176, 176, 200, 303};

  initial begin
    int h, v, ph, pv, fr;
    bit pvalid;
    bit t, p, r, x;

    rst = 1'b1; frame_tick = 1'b0; play = 1'b1; restart = 1'b0;
    hpos = 10'd300; vpos = 10'd200;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_sel", int'(frame_sel), 0);
    chk("rst_lut_x", int'(lut_x), 0);
    chk("rst_lut_y", int'(lut_y), 0);
    chk("rst_color_idx", int'(color_idx), 0);
    chk("rst_sprite_on", int'(sprite_on), 0);
    rst = 1'b0; play = 1'b0; hpos = 10'd0; vpos = 10'd0;

    // Six ticks per frame, wrap after four frames.
    cycle(0, 1, 0, 0);
    repeat (5) cycle(1, 1, 0, 0);
    chk("hold_5_ticks", int'(frame_sel), 0);
    cycle(1, 1, 0, 0);
    chk("adv_6th_tick", int'(frame_sel), 1);
    repeat (18) cycle(1, 1, 0, 0);
`ifdef SPRITE_PINGPONG_EN
    chk("after_24_ticks", int'(frame_sel), 2);
`else
    chk("after_24_ticks", int'(frame_sel), 0);
`endif

    // Pause after three ticks, ticks ignored, resume needs three more.
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    repeat (3) cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    repeat (10) cycle(1, 0, 0, 0);
    chk("paused_hold", int'(frame_sel), 0);
    cycle(0, 1, 0, 0);
    repeat (2) cycle(1, 1, 0, 0);
    chk("resume_2", int'(frame_sel), 0);
    cycle(1, 1, 0, 0);
    chk("resume_3", int'(frame_sel), 1);

    // Restart coinciding with an advancing tick; counter must restart at 0.
    repeat (5) cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 0);
    chk("restart_frame", int'(frame_sel), 0);
    repeat (3) cycle(1, 0, 0, 0);
    chk("restart_idle", int'(frame_sel), 0);
    cycle(0, 1, 0, 0);
    repeat (5) cycle(1, 1, 0, 0);
    chk("restart_cnt0", int'(frame_sel), 0);
    cycle(1, 1, 0, 0);
    chk("restart_cnt_adv", int'(frame_sel), 1);

    // Reset beats restart/tick/play at an advancing tick.
    repeat (5) cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 1);
    chk("rst_priority", int'(frame_sel), 0);

    // Random control traffic.
    for (int i = 0; i < 600; i++) begin
      p = ($urandom_range(0, 9) == 0) ? ~play : play;
      t = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 39) == 0);
      x = ($urandom_range(0, 149) == 0);
      cycle(t, p, r, x);
    end

    // Park the animation on a known frame for the pixel pipeline tests.
    play = 1'b0;
    @(posedge clk); #1;
    m_act = 1'b0;
    fr = fmap(m_k);

    // Pixel pipeline: directed corner points then random beam positions.
    pvalid = 1'b0; ph = 0; pv = 0;
    for (int i = 0; i < 406; i++) begin
      if (i < 6) begin
        h = dh[i]; v = dv[i];
      end else if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(0, 1023); v = $urandom_range(0, 1023);
      end else begin
        h = $urandom_range(X0 - 8, X0 + BOX + 8);
        v = $urandom_range(Y0 - 8, Y0 + BOX + 8);
      end
      hpos = 10'(h); vpos = 10'(v);
      @(posedge clk); #1;
      chk("lut_x", int'(lut_x), box_hit(h, v) ? (h - X0) >> SCL : 0);
      chk("lut_y", int'(lut_y), box_hit(h, v) ? (v - Y0) >> SCL : 0);
      if (pvalid) begin
        chk("color_idx", int'(color_idx),
            box_hit(ph, pv) ? int'(lut_fn(fr, (ph - X0) >> SCL, (pv - Y0) >> SCL)) : 0);
        chk("sprite_on", int'(sprite_on),
            (box_hit(ph, pv) && lut_fn(fr, (ph - X0) >> SCL, (pv - Y0) >> SCL) != 3'd0) ? 1 : 0);
      end
      ph = h; pv = v; pvalid = 1'b1;
    end
    chk("frame_stable", int'(frame_sel), fr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
